// File: rtl/fifo_pkg.sv
// Defaults shared by async_fifo and its read-domain stream stage.
package fifo_pkg;

  localparam int DWIDTH_DEF    = 32;
  localparam int AWIDTH_DEF    = 4;
  localparam int BUF_DEPTH_DEF = 4;
  localparam int CNT_WIDTH_DEF = 32;
  localparam int BUF_PTR_W     = $clog2(BUF_DEPTH_DEF);

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_buf.sv
// Small circular register buffer: push/pop/clear with a read of the
// entry at rd_ptr straight from the storage registers.
module stream_buf
  import fifo_pkg::*;
#(
  parameter int DEPTH  = BUF_DEPTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  localparam int PW    = ptr_width(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic [CW-1:0]     count
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async_fifo read port (one-cycle dout latency) into a
// valid/ready stream, with flush and a completed-transfer counter.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  localparam int CW       = $clog2(BUF_DEPTH) + 1
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 flush,
  input  logic                 fifo_empty,
  output logic                 fifo_rden,
  input  logic [DWIDTH-1:0]    fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DWIDTH-1:0]    m_data,
  output logic [CW-1:0]        buf_count,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  localparam logic [CW:0] DEPTH_LIM = BUF_DEPTH[CW:0];

  logic        inflight;
  logic        push;
  logic        pop;
  logic [CW:0] occupancy;

  // Reserve a slot for the word already requested, so a read is only
  // issued when it is guaranteed to fit; m_ready never reaches fifo_rden.
  assign occupancy = {1'b0, buf_count} + {{CW{1'b0}}, inflight};
  assign fifo_rden = !fifo_empty && !flush && (occupancy < DEPTH_LIM);

  assign push    = inflight && !flush;
  assign m_valid = (buf_count != '0);
  assign pop     = m_valid && m_ready;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      inflight <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      inflight <= fifo_rden;
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  stream_buf #(
    .DEPTH  (BUF_DEPTH),
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk   (rclk),
    .rst   (rrst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_dout),
    .rdata (m_data),
    .count (buf_count)
  );

endmodule
